// File: rtl/router_pkg.sv
// Shared definitions for the wormhole router stage.
//   FLIT_SIZE / ADDR_W : flit and node address widths
//   flit_type_e        : flit type field encoding
//   port_e             : output port indices (LOCAL..WEST)
//   TYPE_* / DEST_*    : head flit field positions
//   xy_route()         : dimension-ordered (X then Y) route for a destination
package router_pkg;
  localparam int FLIT_SIZE = 32;
  localparam int ADDR_W    = 4;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int DEST_HI = 29;
  localparam int DEST_LO = 26;

  typedef enum logic [1:0] {
    FT_HEAD     = 2'b00,
    FT_BODY     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  // X is resolved first, then Y; equal coordinates deliver locally.
  function automatic port_e xy_route(input logic [ADDR_W-1:0] dest,
                                     input logic [ADDR_W-1:0] cur);
    logic [ADDR_W/2-1:0] dx, dy, cx, cy;
    dx = dest[ADDR_W-1:ADDR_W/2];
    dy = dest[ADDR_W/2-1:0];
    cx = cur[ADDR_W-1:ADDR_W/2];
    cy = cur[ADDR_W/2-1:0];
    if (dx > cx)      xy_route = PORT_EAST;
    else if (dx < cx) xy_route = PORT_WEST;
    else if (dy > cy) xy_route = PORT_NORTH;
    else if (dy < cy) xy_route = PORT_SOUTH;
    else              xy_route = PORT_LOCAL;
  endfunction
endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO with occupancy output.
//   clk, rst_n        : clock, async active-low reset
//   wr_en / wr_data   : write request; ignored when full
//   rd_en / rd_data   : pop request; rd_data is the current front (show-ahead)
//   count, full, empty: occupancy status, all from state before the edge
// DEPTH must be a power of two so pointers wrap naturally.
module router_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full is judged before the pop, so write+read while full drops the write.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
    else if (!wr_ok && rd_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/noc_router.sv
// Single-input, five-output wormhole router stage with XY routing.
//   clk, reset_n      : clock, async active-low reset
//   i_flit, i_transmit_req : upstream flit and its valid
//   i_port_addr       : this node's address (X high half, Y low half)
//   o_on_off          : upstream on/off flow control with hysteresis
//   o_flit, o_valid, o_port_sel : registered forwarded flit, one-hot port
//   i_down_on         : per-port downstream readiness
// Define ROUTER_STATS_EN to add o_flits_fwd / o_flits_drop saturating counters.
module noc_router
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int OFF_THRESH = 6,
  parameter int ON_THRESH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FLIT_SIZE-1:0] i_flit,
  input  logic [ADDR_W-1:0]    i_port_addr,
  input  logic                 i_transmit_req,
  output logic                 o_on_off,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_valid,
  output logic [4:0]           o_port_sel,
  input  logic [4:0]           i_down_on
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0]          o_flits_fwd,
  output logic [15:0]          o_flits_drop
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FWD  = 1'b1;

  logic [FLIT_SIZE-1:0] front;
  logic [CW-1:0]        count, occ_nxt;
  logic                 full, empty, push, pop, fwd, discard, drop_in;
  flit_type_e           front_type;
  port_e                route, port_q, port_d;
  logic                 state_q, state_d;
  logic                 on_off_q, on_off_d, valid_q, valid_d;
  logic [FLIT_SIZE-1:0] flit_q, flit_d;
  logic [4:0]           sel_q, sel_d;

  router_fifo #(.WIDTH(FLIT_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (push),
    .wr_data (i_flit),
    .rd_en   (pop),
    .rd_data (front),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign push       = i_transmit_req && !full;
  assign drop_in    = i_transmit_req && full;
  assign front_type = flit_type_e'(front[TYPE_HI:TYPE_LO]);

  always_comb begin
    route   = (state_q == ST_FWD) ? port_q
                                  : xy_route(front[DEST_HI:DEST_LO], i_port_addr);
    pop     = 1'b0;
    fwd     = 1'b0;
    discard = 1'b0;
    state_d = state_q;
    port_d  = port_q;
    if (!empty) begin
      if (state_q == ST_IDLE && (front_type == FT_BODY || front_type == FT_TAIL)) begin
        // Orphan body/tail outside a packet: drop without waiting on downstream.
        pop     = 1'b1;
        discard = 1'b1;
      end else if (i_down_on[route]) begin
        pop = 1'b1;
        fwd = 1'b1;
        if (state_q == ST_IDLE) begin
          port_d = route;
          if (front_type == FT_HEAD) state_d = ST_FWD;
        end else if (front_type == FT_TAIL) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    flit_d  = fwd ? front : flit_q;
    sel_d   = fwd ? (5'd1 << route) : sel_q;
    valid_d = fwd;
    // Hysteresis on the occupancy this edge will produce.
    occ_nxt  = count + CW'(push) - CW'(pop);
    on_off_d = on_off_q;
    if (occ_nxt >= CW'(OFF_THRESH))     on_off_d = 1'b0;
    else if (occ_nxt <= CW'(ON_THRESH)) on_off_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      port_q   <= PORT_LOCAL;
      on_off_q <= 1'b1;
      valid_q  <= 1'b0;
      flit_q   <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      on_off_q <= on_off_d;
      valid_q  <= valid_d;
      flit_q   <= flit_d;
      sel_q    <= sel_d;
    end
  end

  assign o_on_off   = on_off_q;
  assign o_valid    = valid_q;
  assign o_flit     = flit_q;
  assign o_port_sel = sel_q;

`ifdef ROUTER_STATS_EN
  logic [15:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (fwd && fwd_cnt_q != 16'hFFFF) fwd_cnt_d = fwd_cnt_q + 1'b1;
    // An input drop and an IDLE discard can land in the same cycle.
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_in) + 17'(discard);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_flits_fwd  = fwd_cnt_q;
  assign o_flits_drop = drop_cnt_q;
`endif
endmodule

// File: tb/tb_noc_router.sv
module tb_noc_router;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] i_flit = '0;
  logic [3:0]  i_port_addr = '0;
  logic        i_transmit_req = 1'b0;
  logic        o_on_off;
  logic [31:0] o_flit;
  logic        o_valid;
  logic [4:0]  o_port_sel;
  logic [4:0]  i_down_on = 5'b11111;
`ifdef ROUTER_STATS_EN
  logic [15:0] o_flits_fwd, o_flits_drop;
`endif

  noc_router dut (
    .clk(clk), .reset_n(reset_n), .i_flit(i_flit), .i_port_addr(i_port_addr),
    .i_transmit_req(i_transmit_req), .o_on_off(o_on_off), .o_flit(o_flit),
    .o_valid(o_valid), .o_port_sel(o_port_sel), .i_down_on(i_down_on)
`ifdef ROUTER_STATS_EN
    , .o_flits_fwd(o_flits_fwd), .o_flits_drop(o_flits_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered flits, packet-in-progress flag and
  // the locked port, evaluated once per clock edge from the spec's rules.
  logic [31:0] mq[$];
  bit          m_inpkt;
  int          m_port;
  logic        e_on, e_valid;
  logic [31:0] e_flit;
  logic [4:0]  e_sel;
  int          e_fwd, e_drop;

  function automatic int xy(input logic [3:0] d, input logic [3:0] c);
    int dx, dy, cx, cy;
    dx = int'(d) / 4; dy = int'(d) % 4;
    cx = int'(c) / 4; cy = int'(c) % 4;
    if (dx > cx) return 2;
    if (dx < cx) return 4;
    if (dy > cy) return 1;
    if (dy < cy) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_inpkt = 0; m_port = 0;
    e_on = 1; e_valid = 0; e_flit = '0; e_sel = '0;
    e_fwd = 0; e_drop = 0;
  endtask

  task automatic model_step();
    int pre, r, t, occ;
    logic [31:0] f;
    pre = mq.size();
    e_valid = 0;
    if (pre > 0) begin
      f = mq[0];
      t = int'(f[31:30]);
      if (!m_inpkt && (t == 1 || t == 2)) begin
        mq.delete(0);
        e_drop++;
      end else begin
        r = m_inpkt ? m_port : xy(f[29:26], i_port_addr);
        if (i_down_on[r]) begin
          mq.delete(0);
          e_valid = 1; e_flit = f; e_sel = 5'(1 << r); e_fwd++;
          if (!m_inpkt && t == 0) begin m_inpkt = 1; m_port = r; end
          else if (m_inpkt && t == 2) m_inpkt = 0;
        end
      end
    end
    if (i_transmit_req) begin
      if (pre == 8) e_drop++;
      else mq.push_back(i_flit);
    end
    occ = mq.size();
    if (occ >= 6) e_on = 0;
    else if (occ <= 4) e_on = 1;
  endtask

  task automatic cyc(input logic req, input logic [31:0] flit, input logic [4:0] dn);
    @(negedge clk);
    i_transmit_req = req; i_flit = flit; i_down_on = dn;
    @(posedge clk);
    model_step();
    #1;
    chk("valid", o_valid, e_valid);
    chk("flit", o_flit, e_flit);
    chk("port_sel", o_port_sel, e_sel);
    chk("on_off", o_on_off, e_on);
`ifdef ROUTER_STATS_EN
    chk("stat_fwd", o_flits_fwd, e_fwd);
    chk("stat_drop", o_flits_drop, e_drop);
`endif
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] d);
    return {t, d, 26'($urandom)};
  endfunction

  initial begin
    model_reset();
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_on_off", o_on_off, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_sel", o_port_sel, 0);
    chk("rst_flit", o_flit, 0);

    // Headtail routed east
    i_port_addr = 4'b0101;
    begin
      logic [31:0] ht;
      ht = mk(2'b11, 4'b1001);
      cyc(1, ht, 5'b11111);
      cyc(0, 0, 5'b11111);
      chk("ht_valid", o_valid, 1);
      chk("ht_sel_east", o_port_sel, 5'b00100);
      chk("ht_flit", o_flit, ht);
    end

    // Five-flit packet delivered locally, back to back
    i_port_addr = 4'b0000;
    cyc(1, mk(2'b00, 4'b0000), 5'b11111);
    for (int i = 0; i < 3; i++) cyc(1, mk(2'b01, 4'($urandom)), 5'b11111);
    cyc(1, mk(2'b10, 4'($urandom)), 5'b11111);
    cyc(0, 0, 5'b11111);
    chk("pkt_sel_local", o_port_sel, 5'b00001);

    // Stall: fill, drop beyond depth, then drain
    cyc(1, mk(2'b00, 4'b0000), 5'b00000);
    for (int i = 0; i < 11; i++) cyc(1, mk(2'b01, 4'($urandom)), 5'b00000);
    chk("stall_off", o_on_off, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 5'b11111);
    chk("drain_on", o_on_off, 1);
    cyc(1, mk(2'b10, 4'b0), 5'b11111);
    cyc(0, 0, 5'b11111);

    // Orphan body in IDLE
    cyc(1, mk(2'b01, 4'b0011), 5'b11111);
    cyc(0, 0, 5'b11111);
    chk("orphan_novalid", o_valid, 0);

    // Randomized traffic
    for (int p = 0; p < 4; p++) begin
      i_port_addr = 4'($urandom);
      for (int i = 0; i < 150; i++)
        cyc(($urandom_range(0, 9) < 7), mk(2'($urandom), 4'($urandom)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b11111);
    end

    // Reset in the middle of a packet
    for (int i = 0; i < 12; i++) cyc(0, 0, 5'b11111);
    i_port_addr = 4'b0000;
    cyc(1, mk(2'b00, 4'b1111), 5'b11111);
    cyc(1, mk(2'b01, 4'b0), 5'b11111);
    cyc(0, 0, 5'b11111);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_flit", o_flit, 0);
    chk("mid_rst_sel", o_port_sel, 0);
    chk("mid_rst_on", o_on_off, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cyc(1, mk(2'b10, 4'b0), 5'b11111);
    cyc(0, 0, 5'b11111);
    chk("tail_after_rst", o_valid, 0);
    cyc(0, 0, 5'b11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
